// File: rtl/programmer_pkg.sv
// Shared constants for the SAP RAM programmer: control-word bit map, idle word,
// FSM state encoding and the state-to-control-word decode.
package programmer_pkg;

    localparam int SIG_HLT    = 14;
    localparam int SIG_SU     = 13;
    localparam int SIG_CI     = 12;
    localparam int SIG_L_MA_N = 11;
    localparam int SIG_L_MD_N = 10;
    localparam int SIG_CE_N   = 9;
    localparam int SIG_L_R_N  = 8;
    localparam int SIG_L_I_N  = 7;
    localparam int SIG_E_I_N  = 6;
    localparam int SIG_L_A_N  = 5;
    localparam int SIG_E_A    = 4;
    localparam int SIG_E_U    = 3;
    localparam int SIG_CP     = 2;
    localparam int SIG_L_B_N  = 1;
    localparam int SIG_L_O_N  = 0;

    // Active-low strobes parked high, active-high strobes parked low.
    localparam logic [14:0] CTRL_IDLE = 15'h0FE3;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_ADDR   = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WRITE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_VERIFY = 3'd4;

    function automatic logic [14:0] ctrl_decode(input logic [STATE_W-1:0] st);
        logic [14:0] w;
        w = CTRL_IDLE;
        case (st)
            ST_ADDR:   w[SIG_L_MA_N] = 1'b0;
            ST_DATA:   w[SIG_L_MD_N] = 1'b0;
            ST_WRITE:  w[SIG_L_R_N]  = 1'b0;
            ST_VERIFY: w[SIG_CE_N]   = 1'b0;
            default:   w = CTRL_IDLE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the strobe and flags a one-cycle pulse when it
// is seen high after having been low on the previous clock.
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!resetn) d_q <= 1'b0;
        else         d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/ram_programmer.sv
// SAP RAM loader: captures bytes on new_byte edges and sequences MAR/MD/RAM-write
// strobes over the shared bus. Optional readback check: define PROGRAMMER_VERIFY_EN.
module ram_programmer
    import programmer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] ui_in,
    input  logic              new_byte,
    input  logic              set_addr,
    input  logic              programming,
    inout  wire  [DATA_W-1:0] bus,
    output logic [CTRL_W-1:0] ctrl,
    output logic              busy,
    output logic [ADDR_W-1:0] ptr,
    output logic              wrapped,
    output logic              overrun,
`ifdef PROGRAMMER_VERIFY_EN
    output logic              verify_err,
`endif
    output logic [STATE_W-1:0] dbg_state_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               wrapped_q, wrapped_d;
    logic               overrun_q, overrun_d;
    logic               rise;
    logic               bus_en;
    logic [DATA_W-1:0]  bus_val;
`ifdef PROGRAMMER_VERIFY_EN
    logic               verify_err_q, verify_err_d;
`endif

    rise_detect u_rise (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (new_byte),
        .rise_o (rise)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        wrapped_d = wrapped_q;
        overrun_d = overrun_q;
`ifdef PROGRAMMER_VERIFY_EN
        verify_err_d = verify_err_q;
`endif
        if (!programming) begin
            // Aborting mid-sequence returns to IDLE without touching the pointer.
            state_d = ST_IDLE;
        end else begin
            if (rise && state_q != ST_IDLE) overrun_d = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        if (set_addr) begin
                            ptr_d = ui_in[ADDR_W-1:0];
                        end else begin
                            data_d  = ui_in;
                            state_d = ST_ADDR;
                        end
                    end
                end
                ST_ADDR: state_d = ST_DATA;
                ST_DATA: state_d = ST_WRITE;
`ifdef PROGRAMMER_VERIFY_EN
                ST_WRITE: state_d = ST_VERIFY;
                ST_VERIFY: begin
                    if (bus != data_q) verify_err_d = 1'b1;
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (&ptr_q) wrapped_d = 1'b1;
                    state_d = ST_IDLE;
                end
`else
                ST_WRITE: begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (&ptr_q) wrapped_d = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            data_q    <= '0;
            wrapped_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PROGRAMMER_VERIFY_EN
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            wrapped_q <= wrapped_d;
            overrun_q <= overrun_d;
`ifdef PROGRAMMER_VERIFY_EN
            verify_err_q <= verify_err_d;
`endif
        end
    end

    assign bus_en  = programming && (state_q == ST_ADDR || state_q == ST_DATA);
    assign bus_val = (state_q == ST_ADDR) ? DATA_W'(ptr_q) : data_q;
    assign bus     = bus_en ? bus_val : {DATA_W{1'bz}};

    assign ctrl        = CTRL_W'(ctrl_decode(state_q));
    assign busy        = (state_q != ST_IDLE);
    assign ptr         = ptr_q;
    assign wrapped     = wrapped_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;
`ifdef PROGRAMMER_VERIFY_EN
    assign verify_err  = verify_err_q;
`endif

endmodule

// File: tb/tb_ram_programmer.sv
// Directed bench for ram_programmer with a bus-attached RAM model and a write scoreboard.
module tb_ram_programmer;
    import programmer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, new_byte, set_addr, programming;
    logic [7:0]  ui_in;
    wire  [7:0]  bus;
    logic [14:0] ctrl;
    logic        busy, wrapped, overrun;
    logic [3:0]  ptr;
    logic [2:0]  dbg_state;
`ifdef PROGRAMMER_VERIFY_EN
    logic        verify_err;
`endif

    int checks = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    logic [11:0] wr_q[$];
    logic [7:0]  ram [16];
    logic [3:0]  mar = 4'h0;
    logic [7:0]  md = 8'h00;
    logic        corrupt = 1'b0;
    logic [3:0]  m_ptr;

    ram_programmer dut (
        .clk         (clk),
        .resetn      (resetn),
        .ui_in       (ui_in),
        .new_byte    (new_byte),
        .set_addr    (set_addr),
        .programming (programming),
        .bus         (bus),
        .ctrl        (ctrl),
        .busy        (busy),
        .ptr         (ptr),
        .wrapped     (wrapped),
        .overrun     (overrun),
`ifdef PROGRAMMER_VERIFY_EN
        .verify_err  (verify_err),
`endif
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // RAM model: the CE_n read drives the stored byte back (inverted when corrupt).
    assign bus = (ctrl[9] == 1'b0) ? (corrupt ? ~ram[mar] : ram[mar]) : 8'bz;

    always @(negedge clk) begin
        if (ctrl[11] == 1'b0) mar = bus[3:0];
        if (ctrl[10] == 1'b0) md = bus;
        if (ctrl[8] == 1'b0) begin
            ram[mar] = md;
            wr_q.push_back({mar, md});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("idle_timeout", 16'(busy), 16'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ui_in    = b;
        set_addr = 1'b0;
        new_byte = 1'b1;
        exp_q.push_back({m_ptr, b});
        m_ptr++;
        tick();
        new_byte = 1'b0;
        wait_idle();
    endtask

    task automatic check_writes(input string tag);
        logic [11:0] e, o;
        while (exp_q.size() > 0) begin
            if (wr_q.size() == 0) begin
                check({tag, "_missing"}, 16'(wr_q.size()), 16'(exp_q.size()));
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = wr_q.pop_front();
                check(tag, 16'(o), 16'(e));
            end
        end
        check({tag, "_extra"}, 16'(wr_q.size()), 16'h0);
        wr_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        resetn = 1'b0; programming = 1'b0; new_byte = 1'b0; set_addr = 1'b0; ui_in = 8'h00;
        m_ptr = 4'h0;
        repeat (3) tick();
        check("rst_ctrl", 16'(ctrl), 16'h0FE3);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_ptr", 16'(ptr), 16'h0);
        check("rst_wrapped", 16'(wrapped), 16'h0);
        check("rst_overrun", 16'(overrun), 16'h0);
`ifdef PROGRAMMER_VERIFY_EN
        check("rst_verify_err", 16'(verify_err), 16'h0);
`endif
        resetn = 1'b1;
        tick();
        check("idle_state", 16'(dbg_state), 16'(ST_IDLE));

        // First byte, cycle by cycle.
        programming = 1'b1; ui_in = 8'hA5; new_byte = 1'b1;
        exp_q.push_back({m_ptr, 8'hA5});
        m_ptr++;
        tick();
        new_byte = 1'b0;
        check("addr_state", 16'(dbg_state), 16'(ST_ADDR));
        check("addr_ctrl", 16'(ctrl), 16'h07E3);
        check("addr_bus", 16'(bus), 16'h00);
        check("addr_busy", 16'(busy), 16'h1);
        tick();
        check("data_ctrl", 16'(ctrl), 16'h0BE3);
        check("data_bus", 16'(bus), 16'hA5);
        tick();
        check("write_ctrl", 16'(ctrl), 16'h0EE3);
        check("write_ptr_hold", 16'(ptr), 16'h0);
        tick();
`ifdef PROGRAMMER_VERIFY_EN
        check("verify_ctrl", 16'(ctrl), 16'h0DE3);
        tick();
        check("verify_ok", 16'(verify_err), 16'h0);
`endif
        check("first_busy", 16'(busy), 16'h0);
        check("first_ptr", 16'(ptr), 16'h1);
        check_writes("first_write");

        // Load address 14, then wrap through 15 -> 0.
        set_addr = 1'b1; ui_in = 8'h0E; new_byte = 1'b1;
        tick();
        check("setaddr_ptr", 16'(ptr), 16'hE);
        check("setaddr_busy", 16'(busy), 16'h0);
        new_byte = 1'b0; set_addr = 1'b0;
        m_ptr = 4'hE;
        tick();
        send_byte(8'h11);
        check("wrap_before", 16'(wrapped), 16'h0);
        send_byte(8'h22);
        check("wrap_set", 16'(wrapped), 16'h1);
        check("wrap_ptr0", 16'(ptr), 16'h0);
        send_byte(8'h33);
        check("wrap_ptr1", 16'(ptr), 16'h1);
        check_writes("wrap_write");

        // Strobe held high: one operation only.
        ui_in = 8'hC3; new_byte = 1'b1;
        exp_q.push_back({m_ptr, 8'hC3});
        m_ptr++;
        repeat (10) tick();
        new_byte = 1'b0;
        wait_idle();
        tick();
        check("held_overrun", 16'(overrun), 16'h0);
        check("held_ptr", 16'(ptr), 16'(m_ptr));
        check_writes("held_write");

        // Second edge while in DATA is dropped and flagged.
        ui_in = 8'h3C; new_byte = 1'b1;
        exp_q.push_back({m_ptr, 8'h3C});
        m_ptr++;
        tick();
        new_byte = 1'b0;
        tick();
        check("ovr_in_data", 16'(dbg_state), 16'(ST_DATA));
        ui_in = 8'h99; new_byte = 1'b1;
        tick();
        new_byte = 1'b0;
        check("ovr_flag", 16'(overrun), 16'h1);
        wait_idle();
        tick();
        check("ovr_ptr", 16'(ptr), 16'(m_ptr));
        check_writes("ovr_write");

        // Drop programming during ADDR.
        ui_in = 8'h77; new_byte = 1'b1;
        tick();
        check("abort_addr", 16'(dbg_state), 16'(ST_ADDR));
        programming = 1'b0; new_byte = 1'b0;
        tick();
        check("abort_idle", 16'(dbg_state), 16'(ST_IDLE));
        check("abort_ctrl", 16'(ctrl), 16'h0FE3);
        repeat (2) tick();
        check("abort_ptr", 16'(ptr), 16'(m_ptr));
        check_writes("abort_write");

        // Edge with programming low is ignored but still tracked.
        new_byte = 1'b1;
        tick();
        check("noprog_busy", 16'(busy), 16'h0);
        programming = 1'b1;
        tick();
        check("noprog_held_busy", 16'(busy), 16'h0);
        new_byte = 1'b0;
        tick();
        check_writes("noprog_write");

`ifdef PROGRAMMER_VERIFY_EN
        corrupt = 1'b1;
        send_byte(8'hA5);
        check("verify_err_set", 16'(verify_err), 16'h1);
        corrupt = 1'b0;
        check_writes("verify_write");
`endif

        // Reset in the middle of a sequence.
        ui_in = 8'h55; new_byte = 1'b1;
        tick();
        new_byte = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        check("midrst_state", 16'(dbg_state), 16'(ST_IDLE));
        check("midrst_ptr", 16'(ptr), 16'h0);
        check("midrst_overrun", 16'(overrun), 16'h0);
        check("midrst_wrapped", 16'(wrapped), 16'h0);
        resetn = 1'b1;
        repeat (3) tick();
        check_writes("midrst_write");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_programmer.md
# ram_programmer

Parametrised RAM loader for the SAP-style CPU, successor to the single-width programmer. While `programming` is high, it captures each byte presented on `ui_in` at a rising edge of `new_byte` and sequences MAR-address, MAR-data and RAM-write control signals over the shared bus. It adds a settable load address, an address-wrap flag, overrun detection and single-clock-edge (posedge-only) operation.

## Interface
Parameters:
- `DATA_W`, 8, width of bus and `ui_in`.
- `ADDR_W`, 4, RAM address width; the address occupies `bus[ADDR_W-1:0]`.
- `CTRL_W`, 15, control word width; the bit map is fixed as in the CPU control unit.

Ports:
- `clk` in 1: clock; all state changes on posedge.
- `resetn` in 1: synchronous, active-low reset.
- `ui_in` in `DATA_W`: byte to write, or new load address.
- `new_byte` in 1: strobe; a rising edge (level sampled on clk) requests one operation.
- `set_addr` in 1: sampled with the `new_byte` edge; 1 means `ui_in[ADDR_W-1:0]` loads the address pointer and no write occurs.
- `programming` in 1: enables the block and its bus drive.
- `bus` inout `DATA_W`: driven only in ADDR/DATA states with `programming`=1; otherwise Z.
- `ctrl` out `CTRL_W`: control word.
- `busy` out 1: FSM not in IDLE.
- `ptr` out `ADDR_W`: next write address.
- `wrapped` out 1: sticky; set when `ptr` wraps from all-ones to 0.
- `overrun` out 1: sticky; set when a `new_byte` edge arrives while `busy`.

## Operation
- States: IDLE, ADDR, DATA, WRITE (plus VERIFY, see Configuration).
- IDLE: on a `new_byte` edge with `programming`=1:
  - `set_addr`=1: `ptr<=ui_in[ADDR_W-1:0]`; stay in IDLE.
  - `set_addr`=0: latch `ui_in` into `data_q`; go to ADDR.
- ADDR: bus=`ptr` zero-extended; `ctrl[11]` (L_MA_n)=0.
- DATA: bus=`data_q`; `ctrl[10]` (L_MD_n)=0.
- WRITE: `ctrl[8]` (L_R_n)=0; bus Z. On exit, `ptr<=ptr+1` modulo 2^ADDR_W. If `ptr` was all-ones, set `wrapped`. Go to IDLE.
- Edges outside IDLE are dropped and set `overrun`. Edges with `programming`=0 are ignored; the edge detector still tracks `new_byte`.
- `programming` falling in any non-IDLE state: next state IDLE, `ptr` unchanged, no write.
- All other `ctrl` bits hold the idle word `CTRL_IDLE`=15'h0FE3 (active-low bits 11..5,1,0 high; active-high bits low).
- `ctrl`, `busy` and bus drive are decoded from the registered state (Moore).

## Timing
- Reset: state IDLE, `ctrl`=15'h0FE3, `ptr`=0, `data_q`=0, `wrapped`=0, `overrun`=0, `busy`=0, bus Z, `new_byte_d`=0.
- Edge seen at posedge k (`new_byte`=1, `new_byte_d`=0): ADDR in cycle k+1, DATA in k+2, WRITE in k+3, IDLE in k+4 with `ptr` incremented.
- Latency is 3 cycles of `busy` per byte, or 4 with verify. The next edge is accepted at posedge k+4.
- `set_addr` edge: `ptr` updates at posedge k; `busy` stays 0.
- `resetn` low mid-operation wins over everything: IDLE on the next posedge.

## Configuration
- `PROGRAMMER_VERIFY_EN` defined: WRITE goes to VERIFY.
  - VERIFY: `ctrl[9]` (CE_n)=0, bus Z.
  - At the end of VERIFY, compare `bus` with `data_q`. Mismatch sets a sticky `verify_err` output (1 bit, reset 0).
  - `ptr` increments on leaving VERIFY instead of WRITE.
- Not defined: no VERIFY state, no `verify_err` port, 3-cycle sequence.

## Structure
- `programmer_pkg`: `SIG_*` bit-index localparams (14..0 as in the control unit), `CTRL_IDLE`, state enum.
- Sub-module `rise_detect`: registered `new_byte_d` and one-cycle pulse output, reset to 0.
- Top level holds the FSM, pointer, flags and tristate.

## Test plan
- Reset, then `programming`=1, `ui_in`=8'hA5, `new_byte` pulse -> ADDR with bus=8'h00 and ctrl=15'h07E3; DATA with bus=8'hA5 and ctrl=15'h0BE3; WRITE with ctrl=15'h0EE3; then `ptr`=1.
- `set_addr`=1, `ui_in`=8'h0E; then write 3 bytes -> writes hit addresses 14, 15, 0; `wrapped`=1 after the second write; `ptr`=1 at the end.
- `new_byte` held high for 10 cycles -> exactly one write; `overrun`=0.
- Second `new_byte` edge in DATA -> it is ignored, `overrun`=1, only one write occurs.
- `programming` dropped during ADDR -> IDLE next cycle, no WRITE, bus Z, `ptr` unchanged.
- With `PROGRAMMER_VERIFY_EN`, RAM model returning 8'h5A for written 8'hA5 -> `verify_err`=1; with a correct readback, `verify_err` stays 0.
